// File: rtl/alu_im_pc_pkg.sv
// Shared widths, opcode encodings and flag bit positions for the fetch/execute core.
// Pure declarations; no logic.
package alu_im_pc_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    localparam logic [5:0] OP_MOV = 6'b010000;
    localparam logic [5:0] OP_ADD = 6'b010001;
    localparam logic [5:0] OP_SUB = 6'b010010;
    localparam logic [5:0] OP_AND = 6'b010011;
    localparam logic [5:0] OP_OR  = 6'b010100;
    localparam logic [5:0] OP_XOR = 6'b010101;
    localparam logic [5:0] OP_NOT = 6'b010110;
    localparam logic [5:0] OP_LSL = 6'b010111;
    localparam logic [5:0] OP_LSR = 6'b011000;
    localparam logic [5:0] OP_ASR = 6'b011001;
    localparam logic [5:0] OP_INC = 6'b011010;
    localparam logic [5:0] OP_DEC = 6'b011011;
    localparam logic [5:0] OP_CMP = 6'b011100;
    localparam logic [5:0] OP_TST = 6'b011101;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_O = 3;

endpackage

// File: rtl/alu_im_pc_alu_core.sv
// Combinational ALU: decodes opcode/operand select/immediate from one instruction word.
// Latency: zero cycles; backpressure: none.
module alu_im_pc_alu_core
    import alu_im_pc_pkg::*;
(
    input  logic [DATA_W-1:0] i_instr,
    input  logic [DATA_W-1:0] i_reg_x,
    input  logic [DATA_W-1:0] i_reg_y,
    output logic [DATA_W-1:0] o_alu_out,
    output logic [3:0]        o_flags
);

    logic [5:0]        w_opcode;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_arith_b;
    logic [3:0]        w_amt;
    logic [4:0]        w_lsl_idx;
    logic [3:0]        w_rsh_idx;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W:0]   w_diff;
    logic              w_sum_ovf;
    logic              w_diff_ovf;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_o;

    assign w_opcode  = i_instr[15:10];
    assign w_a       = i_instr[9] ? i_reg_y : i_reg_x;
    assign w_b       = {{7{i_instr[8]}}, i_instr[8:0]};
    assign w_amt     = w_b[3:0];
    assign w_lsl_idx = 5'd16 - {1'b0, w_amt};
    assign w_rsh_idx = w_amt - 4'd1;

    // INC/DEC share the adder and subtractor with an implicit operand of one.
    assign w_arith_b = ((w_opcode == OP_INC) || (w_opcode == OP_DEC)) ? DATA_W'(1) : w_b;
    assign w_sum     = {1'b0, w_a} + {1'b0, w_arith_b};
    assign w_diff    = {1'b0, w_a} - {1'b0, w_arith_b};
    assign w_sum_ovf  = (w_a[15] == w_arith_b[15]) && (w_sum[15] != w_a[15]);
    assign w_diff_ovf = (w_a[15] != w_arith_b[15]) && (w_diff[15] != w_a[15]);

    always_comb begin
        w_res = w_a;
        w_c   = 1'b0;
        w_o   = 1'b0;
        case (w_opcode)
            OP_MOV: w_res = w_b;
            OP_ADD, OP_INC: begin
                w_res = w_sum[DATA_W-1:0];
                w_c   = w_sum[DATA_W];
                w_o   = w_sum_ovf;
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                w_res = w_diff[DATA_W-1:0];
                w_c   = w_diff[DATA_W];
                w_o   = w_diff_ovf;
            end
            OP_AND, OP_TST: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            OP_XOR: w_res = w_a ^ w_b;
            OP_NOT: w_res = ~w_a;
            OP_LSL: begin
                w_res = w_a << w_amt;
                w_c   = (w_amt != 4'd0) ? w_a[w_lsl_idx[3:0]] : 1'b0;
            end
            OP_LSR: begin
                w_res = w_a >> w_amt;
                w_c   = (w_amt != 4'd0) ? w_a[w_rsh_idx] : 1'b0;
            end
            OP_ASR: begin
                w_res = $signed(w_a) >>> w_amt;
                w_c   = (w_amt != 4'd0) ? w_a[w_rsh_idx] : 1'b0;
            end
            default: w_res = w_a;
        endcase
    end

    assign o_alu_out      = w_res;
    assign o_flags[FLG_Z] = (w_res == '0);
    assign o_flags[FLG_N] = w_res[DATA_W-1];
    assign o_flags[FLG_C] = w_c;
    assign o_flags[FLG_O] = w_o;

endmodule

// File: rtl/alu_im_pc.sv
// Fetch/execute core: program counter, 1024x16 instruction memory, combinational ALU.
// Latency: PC updates per edge, IM read and ALU are zero-cycle; backpressure: stall holds PC.
module alu_im_pc #(
    parameter int ADDR_W = alu_im_pc_pkg::ADDR_W,
    parameter int DATA_W = alu_im_pc_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              branch,
    input  logic              stall,
    input  logic [DATA_W-1:0] reg_x,
    input  logic [DATA_W-1:0] reg_y,
    output logic [ADDR_W-1:0] instr_address,
    output logic [DATA_W-1:0] instruction,
    output logic [DATA_W-1:0] alu_out,
    output logic [3:0]        flags
);

    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] w_instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (stall) begin
            r_pc <= r_pc;
        end else if (branch) begin
            r_pc <= w_instr[ADDR_W-1:0];
        end else begin
            r_pc <= r_pc + ADDR_W'(1);
        end
    end

    // Memory survives reset so a loaded program can be rerun after a reset pulse.
    always_ff @(posedge clk) begin
        if (en_write) begin
            r_mem[r_pc] <= data_in;
        end
    end

    assign w_instr       = r_mem[r_pc];
    assign instr_address = r_pc;
    assign instruction   = w_instr;

    alu_im_pc_alu_core u_alu (
        .i_instr   (w_instr),
        .i_reg_x   (reg_x),
        .i_reg_y   (reg_y),
        .o_alu_out (alu_out),
        .o_flags   (flags)
    );

endmodule

// File: tb/tb_alu_im_pc.sv
// Directed bench for alu_im_pc: PC stepping/branch/stall/reset, IM load, ALU results and flags.
module tb_alu_im_pc;

    logic        clk;
    logic        reset;
    logic        en_write;
    logic [15:0] data_in;
    logic        branch;
    logic        stall;
    logic [15:0] reg_x;
    logic [15:0] reg_y;
    logic [9:0]  instr_address;
    logic [15:0] instruction;
    logic [15:0] alu_out;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    alu_im_pc dut (
        .clk           (clk),
        .reset         (reset),
        .en_write      (en_write),
        .data_in       (data_in),
        .branch        (branch),
        .stall         (stall),
        .reg_x         (reg_x),
        .reg_y         (reg_y),
        .instr_address (instr_address),
        .instruction   (instruction),
        .alu_out       (alu_out),
        .flags         (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Load one word at the held PC, then check the ALU view of it.
    task automatic alu_vec(input string tag, input logic [15:0] ins, input logic [15:0] rx,
                           input logic [15:0] ry, input logic [15:0] exp_out,
                           input logic [3:0] exp_flg);
        reg_x    = rx;
        reg_y    = ry;
        data_in  = ins;
        en_write = 1'b1;
        stall    = 1'b1;
        step();
        en_write = 1'b0;
        #1;
        check({tag, " out"}, 32'(alu_out), 32'(exp_out));
        check({tag, " flags"}, 32'(flags), 32'(exp_flg));
    endtask

    initial begin
        reset = 1'b0; en_write = 1'b0; data_in = 16'h0; branch = 1'b0; stall = 1'b0;
        reg_x = 16'h0; reg_y = 16'h0;

        // Reset and count
        #3;
        check("pc reset", 32'(instr_address), 32'd0);
        step();
        check("pc held in reset", 32'(instr_address), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("pc count %0d", i), 32'(instr_address), 32'(i));
        end
        data_in = 16'h03FF; en_write = 1'b1; stall = 1'b1;
        step();
        en_write = 1'b0; stall = 1'b0;
        check("stall during write", 32'(instr_address), 32'd3);
        check("write visible at pc", 32'(instruction), 32'h03FF);
        branch = 1'b1;
        step();
        branch = 1'b0;
        check("branch to 1023", 32'(instr_address), 32'd1023);
        step();
        check("pc wrap", 32'(instr_address), 32'd0);

        // Load then run
        en_write = 1'b1; data_in = 16'h4203;
        step();
        data_in = 16'h4001;
        step();
        en_write = 1'b0;
        check("pc after load", 32'(instr_address), 32'd2);
        reset = 1'b0;
        #1;
        check("pc async reset", 32'(instr_address), 32'd0);
        reset = 1'b1;
        #1;
        check("im word0", 32'(instruction), 32'h4203);
        check("mov imm3 out", 32'(alu_out), 32'h0003);
        check("mov imm3 flags", 32'(flags), 32'h0);
        step();
        check("pc1", 32'(instr_address), 32'd1);
        check("mov imm1 out", 32'(alu_out), 32'h0001);
        step();

        // ALU vectors, PC held at 2
        alu_vec("add ovf",     16'h4405, 16'h7FFF, 16'h0000, 16'h8004, 4'b1010);
        alu_vec("add carry",   16'h4405, 16'hFFFF, 16'h0000, 16'h0004, 4'b0100);
        alu_vec("sub borrow",  16'h4801, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110);
        alu_vec("mov sext",    16'h4100, 16'h1111, 16'h2222, 16'hFF00, 4'b0010);
        alu_vec("dec y zero",  16'h6E00, 16'h5555, 16'h0001, 16'h0000, 4'b0001);
        alu_vec("dec ovf",     16'h6C00, 16'h8000, 16'h0000, 16'h7FFF, 4'b1000);
        alu_vec("inc carry",   16'h6800, 16'hFFFF, 16'h0000, 16'h0000, 4'b0101);
        alu_vec("inc ovf",     16'h6800, 16'h7FFF, 16'h0000, 16'h8000, 4'b1010);
        alu_vec("cmp equal",   16'h7005, 16'h0005, 16'h0000, 16'h0000, 4'b0001);
        alu_vec("cmp less",    16'h7005, 16'h0003, 16'h0000, 16'hFFFE, 4'b0110);
        alu_vec("tst zero",    16'h740F, 16'h00F0, 16'h0000, 16'h0000, 4'b0001);
        alu_vec("and",         16'h4DFF, 16'h1234, 16'h0000, 16'h1234, 4'b0000);
        alu_vec("or",          16'h5001, 16'h8000, 16'h0000, 16'h8001, 4'b0010);
        alu_vec("xor",         16'h54F0, 16'h00FF, 16'h0000, 16'h000F, 4'b0000);
        alu_vec("not",         16'h5800, 16'h00FF, 16'h0000, 16'hFF00, 4'b0010);
        alu_vec("lsl carry",   16'h5C01, 16'h8001, 16'h0000, 16'h0002, 4'b0100);
        alu_vec("lsr carry",   16'h6001, 16'h0003, 16'h0000, 16'h0001, 4'b0100);
        alu_vec("asr 4",       16'h6404, 16'h8000, 16'h0000, 16'hF800, 4'b0010);
        alu_vec("asr amt0",    16'h6410, 16'h8000, 16'h0000, 16'h8000, 4'b0010);
        alu_vec("default y",   16'h1600, 16'h0000, 16'hABCD, 16'hABCD, 4'b0010);
        check("pc held by stall", 32'(instr_address), 32'd2);

        // Branch and stall
        stall = 1'b0;
        step(); step(); step();
        check("pc5", 32'(instr_address), 32'd5);
        stall = 1'b1;
        step();
        check("stall holds 5", 32'(instr_address), 32'd5);
        data_in = 16'h000A; en_write = 1'b1;
        step();
        en_write = 1'b0; stall = 1'b0; branch = 1'b1;
        step();
        check("branch to 10", 32'(instr_address), 32'd10);
        stall = 1'b1;
        step();
        check("stall over branch", 32'(instr_address), 32'd10);
        stall = 1'b0; branch = 1'b0;

        // Async reset mid-run
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("pc7", 32'(instr_address), 32'd7);
        #3;
        reset = 1'b0;
        #1;
        check("mid-run reset", 32'(instr_address), 32'd0);
        check("im word0 kept", 32'(instruction), 32'h4203);
        step();
        check("reset held across edge", 32'(instr_address), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("pc1 after reset", 32'(instr_address), 32'd1);
        check("im word1 kept", 32'(instruction), 32'h4001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_im_pc.md
Name: alu_im_pc

Overview:
Fetch-and-execute datapath core for the 16-bit accumulator processor. It holds the program counter (PC), the 1024x16 instruction memory (IM) and the combinational ALU. The PC addresses the IM; the fetched instruction drives the ALU opcode, operand select and immediate. The control unit supplies branch/stall; the X/Y registers and accumulator live outside this block.

Parameters:
ADDR_W, 10, PC/IM address width; IM depth = 2^ADDR_W
DATA_W, 16, instruction and data width

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
en_write  in  1  1 = write data_in into IM at current PC on clk rising edge
data_in  in  16  program word to load
branch  in  1  load PC from instruction[9:0]
stall  in  1  hold PC
reg_x  in  16  register X value
reg_y  in  16  register Y value
instr_address  out  10  current PC
instruction  out  16  IM word at PC
alu_out  out  16  ALU result
flags  out  4  {O,C,N,Z} (bit0 Z, bit1 N, bit2 C, bit3 O)

Behaviour:
- PC: reset low -> instr_address=0 immediately. On each rising edge, priority is stall (hold) > branch (PC<=instruction[9:0]) > PC+1. PC wraps modulo 1024 (1023 -> 0).
- IM: the read is combinational: instruction = mem[PC]. Writes are synchronous when en_write=1. A write at the current PC shows on instruction from the next delta after the edge; the old word is shown before the edge. Reset does not clear the memory. Contents at power-up are don't-care.
- en_write does not affect PC stepping. Program load is done by writing one word per cycle while the PC increments.
- ALU (combinational):
  - A = instruction[9] ? reg_y : reg_x.
  - B = sign-extend(instruction[8:0]) to 16 bits.
  - opcode = instruction[15:10].
- Opcodes:
  - 010000 MOV: out=B
  - 010001 ADD: A+B
  - 010010 SUB: A-B
  - 010011 AND
  - 010100 OR
  - 010101 XOR
  - 010110 NOT: ~A
  - 010111 LSL: A<<B[3:0]
  - 011000 LSR: logical, A>>B[3:0]
  - 011001 ASR: arithmetic, A>>>B[3:0]
  - 011010 INC: A+1
  - 011011 DEC: A-1
  - 011100 CMP: A-B
  - 011101 TST: A&B
  - All other opcodes (including branch/control codes 000000-001111): out=A.
- Flags:
  - Z = (out==0); N = out[15] for every opcode.
  - C = carry-out for ADD/INC; borrow (A<B unsigned) for SUB/DEC/CMP.
  - C = last bit shifted out for shifts with shift amount nonzero; otherwise 0.
  - O = signed overflow for ADD/SUB/INC/DEC/CMP; otherwise 0.
- Reset mid-operation: only the PC is affected. ALU outputs follow the new instruction combinationally.

Decomposition:
- Shared package holds:
  - ADDR_W/DATA_W
  - 6-bit opcode localparams (OP_MOV ... OP_TST)
  - flag bit indices (FLG_Z=0, FLG_N=1, FLG_C=2, FLG_O=3)
- One natural sub-module: alu_core (purely combinational ALU plus flags). PC and IM stay inline.

Test Plan:
1. Reset and count: reset=0 -> instr_address=0 immediately. Release reset, 3 edges with stall=branch=0 -> 1,2,3. Force PC to 1023 via branch, one more edge -> 0.
2. Load then run:
   - en_write=1; write 0x4203 at PC0 and 0x4001 at PC1.
   - Pulse reset, en_write=0.
   - At PC0: instruction=0x4203, alu_out=0x0003, flags=0000.
   - At PC1: alu_out=0x0001.
3. ADD overflow: instruction 0x4405, reg_x=0x7FFF -> alu_out=0x8004, N=1, O=1, C=0, Z=0.
4. SUB borrow and sign-extend:
   - instruction 0x4801, reg_x=0 -> alu_out=0xFFFF, C=1, N=1, O=0.
   - MOV 0x4100 -> alu_out=0xFF00.
   - DEC with reg_y=1 (0x6E00) -> alu_out=0, Z=1.
5. Branch/stall:
   - At PC=5, stall=1 -> PC stays 5.
   - stall=0, branch=1, instruction[9:0]=0x00A -> PC=10.
   - stall=1 and branch=1 together -> PC holds.
6. Async reset mid-run: reset low between edges at PC=7 -> PC=0 before the next edge. Previously loaded IM words read back unchanged.
